pq_shift_param: RTL
===================

// Module: pq_shift_param
// PURPOSE
//   Parametrised shift-register hardware priority queue of <key,value> pairs, generalising the
//   fixed-width pq_pkg interface. Key/value width, capacity and MIN/MAX ordering are set per instance.
//   Adds a single-cycle replace operation (enq+deq), stable FIFO tie-breaking, and per-cell valid
//   bits, so no key value is reserved as a sentinel. Used as the HWPQ reference queue for the study.
// PARAMETERS
//   KEY_WIDTH  4       key (priority) bits
//   VAL_WIDTH  4       value (payload) bits
//   CAPACITY   15      number of storage cells, >=2
//   PQ_TYPE    MIN_PQ  pq_pkg::pq_type_t; MIN_PQ: smallest key at head; MAX_PQ: largest key at head
//   Derived: KVW=KEY_WIDTH+VAL_WIDTH; CW=$clog2(CAPACITY+1)
// PORTS
//   clk      in   1    clock; all state updates on rising edge
//   rst      in   1    synchronous active-high reset
//   enq      in   1    insert kv_in this cycle
//   kv_in    in   KVW  {key,value}; key in MSBs
//   deq      in   1    remove head this cycle
//   kv_out   out  KVW  current head entry (registered); all-zero when empty
//   empty    out  1    count==0
//   full     out  1    count==CAPACITY
//   count    out  CW   number of valid entries
//   err_ovf  out  1    one-cycle pulse: enq rejected because full (no deq that cycle)
//   err_udf  out  1    one-cycle pulse: deq rejected because empty
// BEHAVIOUR
//   - Storage: cells 0..CAPACITY-1, each {valid,key,value}; cell 0 is the head. Valid cells are
//     contiguous from 0 and always sorted by priority. Invalid cells hold all-zero data.
//   - Reset (rst=1 at an edge, overrides enq/deq): all cells invalid and zeroed; count=0, empty=1,
//     full=0, kv_out=0, err_ovf=0, err_udf=0. Applies equally mid-operation; no partial op completes.
//   - Priority: a beats b iff a.key<b.key (MIN_PQ) or a.key>b.key (MAX_PQ). Every key value,
//     including all-zeros and all-ones, is legal.
//   - Ties: stable. A new entry is placed after all existing entries with an equal key.
//   - Latency: 1 cycle. An op sampled at edge N is reflected in kv_out/count/flags after edge N.
//     Back-to-back ops every cycle are supported; there is no busy/stall.
//   - Ops per edge (enq,deq):
//     00: hold.
//     10: if !full, insert: cells behind insert point shift toward tail by one; count+1.
//         If full: contents unchanged; err_ovf=1 for one cycle.
//     01: if !empty, remove head: all cells shift toward head by one, last valid cell cleared;
//         count-1. If empty: no change; err_udf=1 for one cycle.
//     11, !empty: replace. Head removed and kv_in inserted in the same edge; count unchanged.
//         Legal when full (no err_ovf). Result equals a deq followed by an enq.
//     11, empty: enq performed (count becomes 1); deq rejected with err_udf=1.
//   - kv_out always equals cell 0 data. Read it in the same cycle deq is asserted to take the head.
//   - Error pulses are registered and deassert on the next edge unless the condition repeats.
//   - Arithmetic: count stays within 0..CAPACITY, with no wrap. Key comparisons are unsigned,
//     KEY_WIDTH bits.
// TESTING
//   T1 MIN_PQ: enq (5,7),(2,1),(9,3),(2,4) on consecutive cycles -> count=4; 4 deqs give kv_out
//      (2,1),(2,4),(5,7),(9,3) -> empty=1, kv_out=0.
//   T2 Fill with keys 14 down to 0 -> full=1, count=15, kv_out.key=0; enq key 3 -> err_ovf
//      pulses 1 cycle; count=15; the drain gives 0..14 unchanged.
//   T3 After reset, deq -> err_udf pulse, empty=1, count=0, kv_out=0; enq+deq (6,2) on empty ->
//      count=1, kv_out=(6,2), err_udf=1.
//   T4 Full with keys 0..14, enq+deq (7,9) -> no err_ovf, count=15, kv_out.key=1; the drain
//      order has (7,orig) before (7,9).
//   T5 PQ_TYPE=MAX_PQ: enq keys 15,0,8 -> deq order 15,8,0. Sentinel-like keys are retained
//      and count reaches 3.
//   T6 count=3, then rst=1 with enq=1 in the same cycle -> next cycle count=0, empty=1, kv_out=0,
//      and no err pulses.

Source files
------------

// File: rtl/pq_pkg.sv
// pq_pkg: ordering selector shared by priority-queue instances
package pq_pkg;
   typedef enum logic {MIN_PQ, MAX_PQ} pq_type_t;
endpackage

// File: rtl/pq_shift_param_if.sv
// pq_shift_param_if: enqueue/dequeue request and head/status bundle for the priority queue
interface pq_shift_param_if #(
   parameter int KVW = 8,
   parameter int CW  = 4
);
   logic           enq;
   logic           deq;
   logic [KVW-1:0] kv_in;
   logic [KVW-1:0] kv_out;
   logic           empty;
   logic           full;
   logic [CW-1:0]  count;
   logic           err_ovf;
   logic           err_udf;
   modport master (output enq, deq, kv_in, input kv_out, empty, full, count, err_ovf, err_udf);
   modport slave  (input enq, deq, kv_in, output kv_out, empty, full, count, err_ovf, err_udf);
endinterface

// File: rtl/pq_shift_param.sv
// pq_shift_param: shift-register priority queue of {key,value} with per-cell valid bits,
// stable tie order and single-cycle replace (enq+deq).
module pq_shift_param #(
   parameter int               KEY_WIDTH = 4,
   parameter int               VAL_WIDTH = 4,
   parameter int               CAPACITY  = 15,
   parameter pq_pkg::pq_type_t PQ_TYPE   = pq_pkg::MIN_PQ
) (
   input logic             clk,
   input logic             rst,
   pq_shift_param_if.slave pq
);
   localparam int KVW = KEY_WIDTH + VAL_WIDTH;
   localparam int CW  = $clog2(CAPACITY + 1);

   logic [CAPACITY-1:0] vld_q, vld_d, s_vld, goes;
   logic [KVW-1:0]      kv_q [CAPACITY];
   logic [KVW-1:0]      kv_d [CAPACITY];
   logic [KVW-1:0]      s_kv [CAPACITY];
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d, udf_q, udf_d;
   logic                empty, full, do_enq, do_deq;
   logic [KEY_WIDTH-1:0] new_key;

   function automatic logic beats(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
      return (PQ_TYPE == pq_pkg::MIN_PQ) ? (a < b) : (a > b);
   endfunction

   assign new_key = pq.kv_in[KVW-1 -: KEY_WIDTH];

   // s_* is the array after the optional head removal; the insert then lands in s_*.
   // Strict beats() keeps a new entry behind every equal key.
   always_comb begin
      empty  = cnt_q == '0;
      full   = cnt_q == CW'(CAPACITY);
      do_deq = pq.deq && !empty;
      do_enq = pq.enq && (!full || do_deq);
      ovf_d  = pq.enq && !pq.deq && full;
      udf_d  = pq.deq && empty;
      cnt_d  = cnt_q + CW'(do_enq) - CW'(do_deq);
      s_vld  = do_deq ? {1'b0, vld_q[CAPACITY-1:1]} : vld_q;
      for (int k = 0; k < CAPACITY - 1; k++) s_kv[k] = do_deq ? kv_q[k+1] : kv_q[k];
      s_kv[CAPACITY-1] = do_deq ? '0 : kv_q[CAPACITY-1];
      for (int k = 0; k < CAPACITY; k++) goes[k] = !s_vld[k] || beats(new_key, s_kv[k][KVW-1 -: KEY_WIDTH]);
      kv_d[0]  = (do_enq && goes[0]) ? pq.kv_in : s_kv[0];
      vld_d[0] = s_vld[0] || do_enq;
      for (int k = 1; k < CAPACITY; k++) begin
         kv_d[k]  = !(do_enq && goes[k]) ? s_kv[k] : goes[k-1] ? s_kv[k-1] : pq.kv_in;
         vld_d[k] = !(do_enq && goes[k]) ? s_vld[k] : goes[k-1] ? s_vld[k-1] : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         kv_q  <= '{default: '0};
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         kv_q  <= kv_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign pq.kv_out  = kv_q[0];
   assign pq.empty   = empty;
   assign pq.full    = full;
   assign pq.count   = cnt_q;
   assign pq.err_ovf = ovf_q;
   assign pq.err_udf = udf_q;
endmodule
